// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage of the dCPU core.
// Converts an ALU effective address into a word-aligned, byte-enabled
// req/ack memory transaction. Loads return the extracted and extended
// byte/halfword/word as a one-cycle writeback pulse. Misaligned accesses
// are rejected with a one-cycle exception pulse and never reach memory.
// Optional feature macro: LSU_TIMEOUT_EN (BUSY watchdog, exc_timeout pulse).

module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  alucode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [4:0]  rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        exc_misaligned,
    output logic        exc_timeout
);

    // Memory-access opcodes of the dCPU ALU encoding.
    localparam logic [5:0] ALU_LB  = 6'd10;
    localparam logic [5:0] ALU_LH  = 6'd11;
    localparam logic [5:0] ALU_LW  = 6'd12;
    localparam logic [5:0] ALU_LBU = 6'd13;
    localparam logic [5:0] ALU_LHU = 6'd14;
    localparam logic [5:0] ALU_SB  = 6'd15;
    localparam logic [5:0] ALU_SH  = 6'd16;
    localparam logic [5:0] ALU_SW  = 6'd17;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    // Byte enables for an access of the given size at byte offset off.
    function automatic logic [3:0] calc_be(input size_t sz, input logic [1:0] off);
        logic [3:0] be;
        case (sz)
            SZ_B:    be = 4'b0001 << off;
            SZ_H:    be = off[1] ? 4'b1100 : 4'b0011;
            SZ_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Store data replicated across every lane the access could target.
    function automatic logic [31:0] replicate(input size_t sz, input logic [31:0] d);
        logic [31:0] r;
        case (sz)
            SZ_B:    r = {4{d[7:0]}};
            SZ_H:    r = {2{d[15:0]}};
            SZ_W:    r = d;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Halfword ops need addr[0]=0, word ops need addr[1:0]=0; bytes always fit.
    function automatic logic is_misaligned(input size_t sz, input logic [1:0] off);
        logic m;
        case (sz)
            SZ_B:    m = 1'b0;
            SZ_H:    m = off[0];
            SZ_W:    m = (off != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    // Pick the addressed lane out of the read word and sign/zero extend it.
    function automatic logic [31:0] extract(input size_t sz, input logic sgn,
                                            input logic [1:0] off, input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            2'd3:    b = d[31:24];
            default: b = 8'h00;
        endcase
        h = off[1] ? d[31:16] : d[15:0];
        case (sz)
            SZ_B:    r = {{24{sgn & b[7]}}, b};
            SZ_H:    r = {{16{sgn & h[15]}}, h};
            SZ_W:    r = d;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    state_t      state_q;
    logic        ready_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [3:0]  mem_be_q;
    logic [31:0] mem_wdata_q;
    logic [4:0]  rd_q;
    size_t       size_q;
    logic        sign_q;
    logic [1:0]  off_q;
    logic        wb_valid_q;
    logic [4:0]  wb_rd_q;
    logic [31:0] wb_data_q;
    logic        exc_mis_q;

    logic        is_mem_s;
    logic        is_load_s;
    size_t       size_s;
    logic        sign_s;
    logic [1:0]  off_s;
    logic        misaligned_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;

`ifdef LSU_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q;
    logic       exc_to_q;
`else
    logic unused_timeout_s;
    assign unused_timeout_s = (TIMEOUT_CYCLES == 0);
`endif

    // Decode the alucode into access class, size and signedness.
    always_comb begin
        is_mem_s  = 1'b0;
        is_load_s = 1'b0;
        size_s    = SZ_W;
        sign_s    = 1'b0;
        case (alucode)
            ALU_LB:  begin is_mem_s = 1'b1; is_load_s = 1'b1; size_s = SZ_B; sign_s = 1'b1; end
            ALU_LH:  begin is_mem_s = 1'b1; is_load_s = 1'b1; size_s = SZ_H; sign_s = 1'b1; end
            ALU_LW:  begin is_mem_s = 1'b1; is_load_s = 1'b1; size_s = SZ_W; sign_s = 1'b0; end
            ALU_LBU: begin is_mem_s = 1'b1; is_load_s = 1'b1; size_s = SZ_B; sign_s = 1'b0; end
            ALU_LHU: begin is_mem_s = 1'b1; is_load_s = 1'b1; size_s = SZ_H; sign_s = 1'b0; end
            ALU_SB:  begin is_mem_s = 1'b1; is_load_s = 1'b0; size_s = SZ_B; sign_s = 1'b0; end
            ALU_SH:  begin is_mem_s = 1'b1; is_load_s = 1'b0; size_s = SZ_H; sign_s = 1'b0; end
            ALU_SW:  begin is_mem_s = 1'b1; is_load_s = 1'b0; size_s = SZ_W; sign_s = 1'b0; end
            default: begin is_mem_s = 1'b0; is_load_s = 1'b0; size_s = SZ_W; sign_s = 1'b0; end
        endcase
    end

    // Lane enables, replicated store data and alignment check for the request.
    always_comb begin
        off_s        = addr[1:0];
        be_s         = calc_be(size_s, off_s);
        misaligned_s = is_misaligned(size_s, off_s);
        if (is_load_s) begin
            wdata_s = 32'h0000_0000;
        end else begin
            wdata_s = replicate(size_s, wdata);
        end
    end

    // Single FSM: accept in IDLE, hold the transaction in BUSY until ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0000_0000;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'h0000_0000;
            rd_q        <= 5'd0;
            size_q      <= SZ_W;
            sign_q      <= 1'b0;
            off_q       <= 2'b00;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= 32'h0000_0000;
            exc_mis_q   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= 8'd0;
            exc_to_q    <= 1'b0;
`endif
        end else begin
            wb_valid_q <= 1'b0;
            exc_mis_q  <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            exc_to_q   <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && is_mem_s) begin
                        if (misaligned_s) begin
                            exc_mis_q <= 1'b1;
                        end else begin
                            state_q     <= ST_BUSY;
                            ready_q     <= 1'b0;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= ~is_load_s;
                            mem_addr_q  <= {addr[31:2], 2'b00};
                            mem_be_q    <= be_s;
                            mem_wdata_q <= wdata_s;
                            rd_q        <= rd;
                            size_q      <= size_s;
                            sign_q      <= sign_s;
                            off_q       <= off_s;
`ifdef LSU_TIMEOUT_EN
                            cnt_q       <= 8'd0;
`endif
                        end
                    end else begin
                        // Non-memory ops are accepted and dropped silently.
                        state_q <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (mem_ack) begin
                        state_q   <= ST_IDLE;
                        ready_q   <= 1'b1;
                        mem_req_q <= 1'b0;
                        if (!mem_we_q) begin
                            wb_valid_q <= 1'b1;
                            wb_rd_q    <= rd_q;
                            wb_data_q  <= extract(size_q, sign_q, off_q, mem_rdata);
                        end else begin
                            wb_valid_q <= 1'b0;
                        end
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (cnt_q == TO_LAST) begin
                        // Watchdog abort: an ack in this same cycle would have won above.
                        state_q   <= ST_IDLE;
                        ready_q   <= 1'b1;
                        mem_req_q <= 1'b0;
                        exc_to_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
`else
                    else begin
                        state_q <= ST_BUSY;
                    end
`endif
                end
                default: begin
                    state_q   <= ST_IDLE;
                    ready_q   <= 1'b1;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready      = ready_q;
    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_be         = mem_be_q;
    assign mem_wdata      = mem_wdata_q;
    assign wb_valid       = wb_valid_q;
    assign wb_rd          = wb_rd_q;
    assign wb_data        = wb_data_q;
    assign exc_misaligned = exc_mis_q;
`ifdef LSU_TIMEOUT_EN
    assign exc_timeout    = exc_to_q;
`else
    assign exc_timeout    = 1'b0;
`endif

endmodule
